pc_sequencer: RTL

- Controls the fetch-stage PC register. Each cycle it computes the PC register's next address and its stall control.
- Arbitrates between sequential fetch, taken branches, jumps, call/return (via a small return-address stack), hazard stalls and halt.
- Flags an IF/ID flush on every redirect.
- Sits between the hazard/branch-resolution logic and the PC register: pcNext drives the PC's inAddress, and pcStall drives the PC's pcStall.

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/ras_stack.sv | 47 ++++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: FSM states,
// next-PC select codes and the default address width.
package pc_seq_pkg;

  localparam int ADDR_W_DEF = 12;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEQ,
    BR,
    JMP,
    CALL,
    RET,
    HOLD
  } pc_sel_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry and leaves the count saturated at DEPTH.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] top_ptr;

  assign top_ptr = wr_ptr - PW'(1);
  assign dout    = mem[top_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - CW'(1);
    end
  end

  // Entry storage needs no reset; count gates every read that matters.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: picks the PC register's next address and stall,
// arbitrating branch/jump/call/return/hazard/halt, and flags IF/ID flushes.
//
// state | meaning
// BOOT  | single cycle after reset, PC held at 0
// RUN   | normal fetch under the redirect priority chain
// HALT  | PC frozen until resume
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RAS_DEPTH = 4,
  parameter int INC       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] curAddress,
  input  logic              hazardStall,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchTarget,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jumpTarget,
  input  logic              call,
  input  logic [ADDR_W-1:0] callTarget,
  input  logic [ADDR_W-1:0] retAddr,
  input  logic              ret,
  input  logic [ADDR_W-1:0] retFallback,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] pcNext,
  output logic              pcStall,
  output logic              flushIFID,
  output logic              rasOverflow,
  output logic              rasUnderflow
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] INC_A = ADDR_W'(INC);

  state_t            state, state_nxt;
  pc_sel_t           sel;
  logic              ras_push, ras_pop, ras_full, ras_empty;
  logic              ovf_set, unf_set;
  logic [ADDR_W-1:0] ras_top;
  logic [CW-1:0]     ras_count;

  ras_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (retAddr),
    .dout  (ras_top),
    .full  (ras_full),
    .empty (ras_empty),
    .count (ras_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel       = SEQ;
    pcStall   = 1'b0;
    flushIFID = 1'b0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    case (state)
      BOOT: begin
        sel       = HOLD;
        pcStall   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (branchTaken) sel = BR;
        else if (jump) sel = JMP;
        else if (call) begin
          sel      = CALL;
          ras_push = 1'b1;
          ovf_set  = ras_full;
        end else if (ret) begin
          sel     = RET;
          ras_pop = !ras_empty;
          unf_set = ras_empty;
        end else if (hazardStall) begin
          sel     = HOLD;
          pcStall = 1'b1;
        end
        flushIFID = (sel inside {BR, JMP, CALL, RET});
        // The winning action still completes on the halting cycle.
        if (halt) state_nxt = HALT;
      end
      HALT: begin
        sel     = HOLD;
        pcStall = 1'b1;
        if (resume) state_nxt = RUN;
      end
      default: begin
        sel       = HOLD;
        pcStall   = 1'b1;
        state_nxt = BOOT;
      end
    endcase
  end

  always_comb begin
    pcNext = curAddress + INC_A;
    case (sel)
      BR:      pcNext = branchTarget;
      JMP:     pcNext = jumpTarget;
      CALL:    pcNext = callTarget;
      RET:     pcNext = ras_empty ? retFallback : ras_top;
      HOLD:    pcNext = curAddress;
      default: pcNext = curAddress + INC_A;
    endcase
    if (state == BOOT) pcNext = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rasOverflow  <= 1'b0;
      rasUnderflow <= 1'b0;
    end else begin
      if (ovf_set) rasOverflow  <= 1'b1;
      if (unf_set) rasUnderflow <= 1'b1;
    end
  end

  a_ras_count_bound: assert property (@(posedge clk) disable iff (rst)
    ras_count <= CW'(RAS_DEPTH));

endmodule
